spike_event_encoder: RTL and testbench

- Downstream consumer of the neuron pair's spike outputs (pre-synaptic and post-synaptic spike levels).
- Converts each spike rising edge into a timestamped address-event {channel, lost, timestamp}.
- Buffers events in a small FIFO and streams each event as two bytes over a valid/ready byte interface, for off-chip spike-timing readout and STDP observation.

---
 rtl/spike_event_encoder.sv | 133 +++++++++++++
 tb/tb_spike_event_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_encoder.sv
// Spike address-event encoder: timestamps pre/post spike rising edges and streams
// {channel, lost, timestamp} words as two bytes over a valid/ready byte port.
`timescale 1ns/1ps
module spike_event_encoder #(
  parameter int TS_WIDTH   = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  input  logic [1:0]           spike_in,
  input  logic                 clr_ovf,
  output logic [7:0]           evt_data,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CNT_WIDTH-1:0] fifo_count,
  output logic                 overflow
);
  // state | meaning
  // IDLE  | no event held; pops the FIFO as soon as it is non-empty
  // HI    | presenting the upper byte of shreg
  // LO    | presenting the lower byte; on accept pops the next event with no bubble
  typedef enum logic [1:0] {IDLE, HI, LO} ser_state_t;

  localparam int EW = TS_WIDTH + 2;
  localparam int PW = CNT_WIDTH - 1;

  ser_state_t          state, state_nxt;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] pend_ts [2];
  logic [1:0]          spike_q, spike_edge, pend_full, lost, push_ch, drop;
  logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]       shreg, push_word;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic                fifo_empty, fifo_full, push_ok, push, pop;

  assign spike_edge = spike_in & ~spike_q & {2{ena}};
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_WIDTH'(FIFO_DEPTH));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    evt_valid = 1'b0;
    evt_data  = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = HI;
        end
      end
      HI: begin
        evt_valid = 1'b1;
        evt_data  = shreg[EW-1 -: 8];
        if (evt_ready) state_nxt = LO;
      end
      LO: begin
        evt_valid = 1'b1;
        evt_data  = shreg[7:0];
        if (evt_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = HI;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign push_ok    = !fifo_full || pop;
  assign push_ch[0] = push_ok & pend_full[0];
  assign push_ch[1] = push_ok & pend_full[1] & ~pend_full[0];
  assign push       = |push_ch;
  assign drop       = spike_edge & pend_full & ~push_ch;
  assign push_word  = push_ch[0] ? {1'b0, lost[0], pend_ts[0]} : {1'b1, lost[1], pend_ts[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt     <= '0;
      spike_q    <= '0;
      pend_full  <= '0;
      lost       <= '0;
      pend_ts[0] <= '0;
      pend_ts[1] <= '0;
      overflow   <= 1'b0;
    end else begin
      spike_q <= spike_in;
      if (ena) ts_cnt <= ts_cnt + 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (drop[c])         lost[c] <= 1'b1;
        else if (push_ch[c]) lost[c] <= 1'b0;
        if (spike_edge[c] && !drop[c]) begin
          pend_full[c] <= 1'b1;
          pend_ts[c]   <= ts_cnt;
        end else if (push_ch[c]) begin
          pend_full[c] <= 1'b0;
        end
      end
      if (|drop)        overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      shreg      <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        shreg  <= fifo_mem[rd_ptr];
      end
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_spike_event_encoder.sv
// Bench for spike_event_encoder: a queue-based event model fed from the stimulus and
// a byte monitor that reassembles events and compares them against the model.
`timescale 1ns/1ps
module tb_spike_event_encoder;
  localparam int TSW = 14;

  logic       clk = 1'b0, reset = 1'b1, ena = 1'b0, clr_ovf = 1'b0, evt_ready = 1'b0;
  logic [1:0] spike_in = 2'b00;
  logic [7:0] evt_data;
  logic       evt_valid, overflow;
  logic [2:0] fifo_count;

  int checks = 0, errors = 0, mon_checks = 0, mon_errors = 0;
  int mon_idx = 0, mon_events = 0, n_stall = 0;
  logic        hold = 1'b0;
  logic [15:0] sb_q[$];
  logic [15:0] m_word, last_word, got;
  logic [TSW-1:0] m_ts;
  logic [1:0]  m_prev;
  logic        mphase, prev_stall, want_b2b;
  logic [7:0]  prev_data, hi_byte;

  spike_event_encoder #(.TS_WIDTH(14), .FIFO_DEPTH(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .ena(ena), .spike_in(spike_in), .clr_ovf(clr_ovf),
    .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .fifo_count(fifo_count), .overflow(overflow));

  always #5 clk = ~clk;

  // Reference model: every rising spike level seen while enabled becomes one event
  // stamped with the number of enabled cycles since reset (mod 2^14); channel 0 first.
  // While the sink is held stalled from empty, the block can hold 6 events (serializer,
  // 4 FIFO entries, one pending slot); later edges are lost and flag the last held event.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ts    = '0;
      m_prev  = '0;
      n_stall = 0;
      sb_q.delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (ena && spike_in[c] && !m_prev[c]) begin
          m_word = {1'(c), 1'b0, m_ts};
          if (!hold) begin
            sb_q.push_back(m_word);
          end else if (n_stall < 6) begin
            sb_q.push_back(m_word);
            n_stall++;
          end else begin
            m_word = sb_q[sb_q.size()-1];
            m_word[14] = 1'b1;
            sb_q[sb_q.size()-1] = m_word;
          end
        end
      end
      if (!hold) n_stall = 0;
      m_prev = spike_in;
      if (ena) m_ts = m_ts + 1'b1;
    end
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      mphase = 1'b0; prev_stall = 1'b0; want_b2b = 1'b0;
      mon_idx = 0; mon_events = 0;
    end else begin
      if (prev_stall) begin
        mon_checks++;
        if (evt_valid !== 1'b1 || evt_data !== prev_data) begin
          mon_errors++;
          $display("FAIL stall_hold: valid=%0b data=%02h required valid=1 data=%02h", evt_valid, evt_data, prev_data);
        end
      end
      if (want_b2b) begin
        mon_checks++;
        if (evt_valid !== 1'b1) begin
          mon_errors++;
          $display("FAIL b2b_no_bubble: valid=%0b required 1", evt_valid);
        end
      end
      want_b2b = 1'b0;
      if (evt_valid && evt_ready) begin
        if (!mphase) begin
          hi_byte = evt_data;
          mphase  = 1'b1;
        end else begin
          mphase    = 1'b0;
          got       = {hi_byte, evt_data};
          last_word = got;
          mon_events++;
          mon_checks++;
          if (mon_idx >= sb_q.size()) begin
            mon_errors++;
            $display("FAIL event_unexpected: got %04h required none", got);
          end else begin
            if (got !== sb_q[mon_idx]) begin
              mon_errors++;
              $display("FAIL event_word #%0d: got %04h required %04h", mon_idx, got, sb_q[mon_idx]);
            end
            mon_idx++;
          end
          want_b2b = (fifo_count != 0);
        end
      end
      prev_stall = evt_valid && !evt_ready;
      prev_data  = evt_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ts(input logic [TSW-1:0] v);
    int n = 0;
    while (m_ts != v) begin
      tick(1);
      n++;
      if (n > 20000) begin
        checks++; errors++;
        $display("FAIL wait_ts_timeout: ts=%0h required %0h", m_ts, v);
        return;
      end
    end
  endtask

  task automatic pulse(input logic [1:0] m, input int hi, input int lo);
    spike_in = m;
    tick(hi);
    spike_in = 2'b00;
    tick(lo);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(sb_q.size() == mon_idx && fifo_count == 0 && !evt_valid)) begin
      tick(1);
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL %s_drain_timeout: outstanding=%0d required 0", name, sb_q.size() - mon_idx);
        return;
      end
    end
    tick(3);
  endtask

  task automatic run_random();
    int hi_len[2], lo_len[2];
    int start = sb_q.size();
    bit done = 0;
    hi_len = '{0, 0};
    lo_len = '{9, 9};
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      tick(1);
      evt_ready = 1'($urandom_range(0, 1));
      for (int c = 0; c < 2; c++) begin
        if (spike_in[c]) begin
          hi_len[c]++;
          if (hi_len[c] >= 2 && $urandom_range(0, 1) == 1) begin
            spike_in[c] = 1'b0;
            lo_len[c] = 0;
          end
        end else begin
          lo_len[c]++;
          if (lo_len[c] >= 2 && (sb_q.size() - start) < 20 && (sb_q.size() - mon_idx) < 2
              && $urandom_range(0, 2) == 0) begin
            spike_in[c] = 1'b1;
            hi_len[c] = 0;
          end
        end
      end
      done = (sb_q.size() - start) >= 20 && spike_in == 2'b00 && sb_q.size() == mon_idx
             && !evt_valid && fifo_count == 0;
    end
    spike_in  = 2'b00;
    evt_ready = 1'b1;
    check("t5_random_complete", 32'(done), 1);
  endtask

  initial begin
    int base;
    tick(3);
    check("rst_valid", evt_valid, 0);
    check("rst_data", evt_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0; ena = 1'b1; evt_ready = 1'b1;

    wait_ts(14'd10);
    pulse(2'b01, 5, 3);
    wait_drain("t1");
    check("t1_events", mon_events, 1);
    check("t1_word", last_word, 16'h000A);
    check("t1_count", fifo_count, 0);

    wait_ts(14'h1234);
    pulse(2'b11, 2, 2);
    wait_drain("t2");
    check("t2_events", mon_events, 3);
    check("t2_last_word", last_word, 16'h9234);

    evt_ready = 1'b0; hold = 1'b1;
    repeat (7) pulse(2'b01, 2, 2);
    hold = 1'b0;
    tick(4);
    check("t3_count_sat", fifo_count, 4);
    check("t3_ovf_set", overflow, 1);
    check("t3_valid_stalled", evt_valid, 1);
    evt_ready = 1'b1;
    wait_drain("t3");
    check("t3_events", mon_events, 9);
    check("t3_last_lost", last_word[14], 1);
    check("t3_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    check("t3_ovf_clr", overflow, 0);

    tick(16389);
    pulse(2'b10, 2, 2);
    wait_drain("t4_wrap");
    check("t4_wrap_events", mon_events, 10);
    ena = 1'b0;
    pulse(2'b01, 2, 3);
    tick(3);
    check("t4_ena0_count", fifo_count, 0);
    check("t4_ena0_valid", evt_valid, 0);
    check("t4_ena0_events", mon_events, 10);
    ena = 1'b1;
    pulse(2'b01, 2, 2);
    wait_drain("t4_frozen");
    check("t4_frozen_events", mon_events, 11);

    base = mon_events;
    run_random();
    wait_drain("t5");
    check("t5_min_events", 32'((mon_events - base) >= 20), 1);

    evt_ready = 1'b0;
    repeat (4) pulse(2'b01, 2, 2);
    tick(3);
    check("t6_pre_count", fifo_count, 3);
    evt_ready = 1'b1; tick(1); evt_ready = 1'b0;
    check("t6_in_lo_valid", evt_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", evt_valid, 0);
    check("t6_rst_count", fifo_count, 0);
    check("t6_rst_data", evt_data, 0);
    tick(1);
    reset = 1'b0; evt_ready = 1'b1;
    wait_ts(14'd1);
    pulse(2'b01, 2, 2);
    wait_drain("t6");
    check("t6_events", mon_events, 1);
    check("t6_word", last_word, 16'h0001);

    checks += mon_checks;
    errors += mon_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
